// File: rtl/pipe_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scheduler_pkg
// Description : Shared game-state encodings, pipe geometry and display size
//               constants used by the scheduler, renderer and game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_scheduler_pkg;

    // One-hot game_state encodings driven by the top-level game FSM
    localparam logic [3:0] c_gs_start_screen = 4'b0001;
    localparam logic [3:0] c_gs_in_game      = 4'b0010;
    localparam logic [3:0] c_gs_pause        = 4'b0100;
    localparam logic [3:0] c_gs_end_screen   = 4'b1000;

    localparam int c_display_w    = 640;
    localparam int c_display_h    = 480;
    localparam int c_pipe_width   = 52;
    localparam int c_pipe_spacing = 180;
    localparam int c_pipe_gap     = 100;

    // Scheduler state encoding
    localparam logic [1:0] c_st_layout = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_frozen = 2'd2;

endpackage : pipe_scheduler_pkg
`default_nettype wire

// File: rtl/pipe_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : pipe_lfsr
// Description : 16-bit Fibonacci LFSR (taps 15,13,12,10) with step enable;
//               exposes the value it will hold after the next step.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step,
    output logic [15:0] o_next
);

    logic [15:0] r_lfsr;

    assign o_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= o_next;
        end
    end

endmodule : pipe_lfsr
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scheduler
// Description : Lays out, scrolls, recycles and scores the four game pipes
//               under control of the one-hot game_state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_scheduler
    import pipe_scheduler_pkg::*;
#(
    parameter int          NUM_PIPES    = 4,
    parameter int          START_X      = 640,
    parameter int          PIPE_SPACING = c_pipe_spacing,
    parameter int          PIPE_WIDTH   = c_pipe_width,
    parameter int          SCROLL_STEP  = 1,
    parameter int          GAP_Y_MIN    = 150,
    parameter int          GAP_Y_RANGE  = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          SCORE_MAX    = 999
) (
    input  logic               GAME_clk,
    input  logic               rst,
    input  logic [3:0]         game_state,
    input  logic signed [31:0] birdX,
    output logic signed [31:0] pipeX_1,
    output logic signed [31:0] pipeX_2,
    output logic signed [31:0] pipeX_3,
    output logic signed [31:0] pipeX_4,
    output logic signed [31:0] pipeY_1,
    output logic signed [31:0] pipeY_2,
    output logic signed [31:0] pipeY_3,
    output logic signed [31:0] pipeY_4,
    output logic [9:0]         score,
    output logic               score_pulse,
    output logic               scrolling
);

    localparam logic signed [31:0] c_step    = SCROLL_STEP;
    localparam logic signed [31:0] c_width   = PIPE_WIDTH;
    localparam logic signed [31:0] c_wrap    = NUM_PIPES * PIPE_SPACING;
    localparam logic signed [31:0] c_gap_min = GAP_Y_MIN;
    localparam logic signed [31:0] c_gap_mid = GAP_Y_MIN + GAP_Y_RANGE / 2;
    localparam logic [15:0]        c_gap_msk = 16'(GAP_Y_RANGE - 1);
    localparam logic [9:0]         c_max     = 10'(SCORE_MAX);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [15:0]          w_lfsr_next;
    logic                 w_lfsr_step;
    logic signed [31:0]   w_gap_y;
    logic [NUM_PIPES-1:0] w_cross;
    logic [NUM_PIPES-1:0] w_respawn;
    logic signed [31:0]   w_pos_x [NUM_PIPES];
    logic signed [31:0]   w_pos_y [NUM_PIPES];
    logic [9:0]           r_score;
    logic                 r_score_pulse;
    logic                 r_scrolling;

    // State is the registered decode of game_state; anything not recognised freezes
    always_ff @(posedge GAME_clk) begin
        if (rst) begin
            r_state <= c_st_layout;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = c_st_frozen;
        case (game_state)
            c_gs_start_screen: w_state_next = c_st_layout;
            c_gs_in_game:      w_state_next = c_st_run;
            default:           w_state_next = c_st_frozen;
        endcase
    end

    // Title-screen time doubles as an entropy source for gap heights
    assign w_lfsr_step = (r_state == c_st_layout) || ((r_state == c_st_run) && (|w_respawn));
    assign w_gap_y     = c_gap_min + $signed({16'd0, w_lfsr_next & c_gap_msk});

    pipe_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (GAME_clk),
        .rst    (rst),
        .i_step (w_lfsr_step),
        .o_next (w_lfsr_next)
    );

    for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
        localparam logic signed [31:0] c_home_x = START_X + k * PIPE_SPACING;

        logic signed [31:0] r_x;
        logic signed [31:0] r_y;
        logic signed [31:0] w_nx;

        assign w_nx         = r_x - c_step;
        assign w_respawn[k] = (w_nx <= -c_width);
        // Crossing uses the pre-wrap position so a respawn cannot mask it
        assign w_cross[k]   = ((r_x + c_width) >= birdX) && ((w_nx + c_width) < birdX);

        always_ff @(posedge GAME_clk) begin
            if (rst || (r_state == c_st_layout)) begin
                r_x <= c_home_x;
                r_y <= c_gap_mid;
            end else if (r_state == c_st_run) begin
                if (w_respawn[k]) begin
                    r_x <= w_nx + c_wrap;
                    r_y <= w_gap_y;
                end else begin
                    r_x <= w_nx;
                end
            end
        end

        assign w_pos_x[k] = r_x;
        assign w_pos_y[k] = r_y;
    end

    always_ff @(posedge GAME_clk) begin
        if (rst) begin
            r_score       <= 10'd0;
            r_score_pulse <= 1'b0;
            r_scrolling   <= 1'b0;
        end else begin
            case (r_state)
                c_st_layout: begin
                    r_score       <= 10'd0;
                    r_score_pulse <= 1'b0;
                    r_scrolling   <= 1'b0;
                end
                c_st_run: begin
                    r_scrolling   <= 1'b1;
                    r_score_pulse <= |w_cross;
                    if ((|w_cross) && (r_score != c_max)) begin
                        r_score <= r_score + 10'd1;
                    end
                end
                default: begin
                    r_score_pulse <= 1'b0;
                    r_scrolling   <= 1'b0;
                end
            endcase
        end
    end

    assign pipeX_1     = w_pos_x[0];
    assign pipeX_2     = w_pos_x[1];
    assign pipeX_3     = w_pos_x[2];
    assign pipeX_4     = w_pos_x[3];
    assign pipeY_1     = w_pos_y[0];
    assign pipeY_2     = w_pos_y[1];
    assign pipeY_3     = w_pos_y[2];
    assign pipeY_4     = w_pos_y[3];
    assign score       = r_score;
    assign score_pulse = r_score_pulse;
    assign scrolling   = r_scrolling;

endmodule : pipe_scheduler
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_scheduler
// Description : Directed self-checking bench for pipe_scheduler: layout,
//               scrolling, scoring, respawn, pause, saturation and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_scheduler;

    logic               GAME_clk;
    logic               rst;
    logic [3:0]         game_state;
    logic signed [31:0] birdX;
    logic signed [31:0] pipeX_1, pipeX_2, pipeX_3, pipeX_4;
    logic signed [31:0] pipeY_1, pipeY_2, pipeY_3, pipeY_4;
    logic [9:0]         score;
    logic               score_pulse;
    logic               scrolling;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_scheduler dut (
        .GAME_clk    (GAME_clk),
        .rst         (rst),
        .game_state  (game_state),
        .birdX       (birdX),
        .pipeX_1     (pipeX_1),
        .pipeX_2     (pipeX_2),
        .pipeX_3     (pipeX_3),
        .pipeX_4     (pipeX_4),
        .pipeY_1     (pipeY_1),
        .pipeY_2     (pipeY_2),
        .pipeY_3     (pipeY_3),
        .pipeY_4     (pipeY_4),
        .score       (score),
        .score_pulse (score_pulse),
        .scrolling   (scrolling)
    );

    initial GAME_clk = 1'b0;
    always #5 GAME_clk = ~GAME_clk;

    // Inputs are driven and outputs sampled on the falling edge
    task automatic tick(input int k);
        repeat (k) @(negedge GAME_clk);
    endtask

    function automatic logic [15:0] lfsr_after(input int steps);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < steps; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; game_state = 4'b0001; birdX = 100;
        tick(2);
        n_cmp++; if (pipeX_1 !== 640 || pipeX_2 !== 820 || pipeX_3 !== 1000 || pipeX_4 !== 1180) begin
            n_bad++; $display("FAIL reset_x: got %0d %0d %0d %0d want 640 820 1000 1180", pipeX_1, pipeX_2, pipeX_3, pipeX_4); end
        n_cmp++; if (pipeY_1 !== 182 || pipeY_2 !== 182 || pipeY_3 !== 182 || pipeY_4 !== 182) begin
            n_bad++; $display("FAIL reset_y: got %0d %0d %0d %0d want 182", pipeY_1, pipeY_2, pipeY_3, pipeY_4); end
        n_cmp++; if (score !== 10'd0 || score_pulse !== 1'b0 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got score=%0d pulse=%b scroll=%b want 0 0 0", score, score_pulse, scrolling); end
        rst = 1'b0;
    endtask

    task automatic test_layout();
        tick(5);
        n_cmp++; if (pipeX_1 !== 640 || pipeX_4 !== 1180 || pipeY_3 !== 182) begin
            n_bad++; $display("FAIL layout_hold: got x1=%0d x4=%0d y3=%0d want 640 1180 182", pipeX_1, pipeX_4, pipeY_3); end
        n_cmp++; if (score !== 10'd0 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL layout_flags: got score=%0d scroll=%b want 0 0", score, scrolling); end
    endtask

    // Six title-screen LFSR steps happen before the first move
    task automatic test_scroll();
        game_state = 4'b0010;
        tick(11);
        n_cmp++; if (pipeX_1 !== 630 || pipeX_2 !== 810 || pipeX_3 !== 990 || pipeX_4 !== 1170) begin
            n_bad++; $display("FAIL scroll_x: got %0d %0d %0d %0d want 630 810 990 1170", pipeX_1, pipeX_2, pipeX_3, pipeX_4); end
        n_cmp++; if (scrolling !== 1'b1 || pipeY_1 !== 182 || pipeY_4 !== 182) begin
            n_bad++; $display("FAIL scroll_flags: got scroll=%b y1=%0d y4=%0d want 1 182 182", scrolling, pipeY_1, pipeY_4); end
    endtask

    task automatic test_score();
        tick(582);
        n_cmp++; if (score_pulse !== 1'b0 || score !== 10'd0) begin
            n_bad++; $display("FAIL score_before: got pulse=%b score=%0d want 0 0", score_pulse, score); end
        tick(1);
        n_cmp++; if (score_pulse !== 1'b1 || score !== 10'd1 || pipeX_1 !== 47) begin
            n_bad++; $display("FAIL score_cross: got pulse=%b score=%0d x1=%0d want 1 1 47", score_pulse, score, pipeX_1); end
        tick(1);
        n_cmp++; if (score_pulse !== 1'b0 || score !== 10'd1) begin
            n_bad++; $display("FAIL score_after: got pulse=%b score=%0d want 0 1", score_pulse, score); end
    endtask

    task automatic test_respawn();
        logic signed [31:0] exp_y;
        exp_y = 150 + int'(lfsr_after(7) & 16'h003F);
        tick(97);
        n_cmp++; if (pipeX_1 !== -51) begin
            n_bad++; $display("FAIL prespawn_x1: got %0d want -51", pipeX_1); end
        tick(1);
        n_cmp++; if (pipeX_1 !== 668 || pipeY_1 !== exp_y) begin
            n_bad++; $display("FAIL respawn_1: got x1=%0d y1=%0d want 668 %0d", pipeX_1, pipeY_1, exp_y); end
        n_cmp++; if (pipeY_1 < 150 || pipeY_1 > 213) begin
            n_bad++; $display("FAIL respawn_range: got y1=%0d want 150..213", pipeY_1); end
        n_cmp++; if (pipeX_2 !== 128 || pipeY_2 !== 182 || pipeX_4 !== 488 || pipeY_4 !== 182) begin
            n_bad++; $display("FAIL respawn_others: got x2=%0d y2=%0d x4=%0d y4=%0d want 128 182 488 182", pipeX_2, pipeY_2, pipeX_4, pipeY_4); end
        tick(81);
        n_cmp++; if (score_pulse !== 1'b1 || score !== 10'd2 || pipeX_2 !== 47) begin
            n_bad++; $display("FAIL score_pipe2: got pulse=%b score=%0d x2=%0d want 1 2 47", score_pulse, score, pipeX_2); end
    endtask

    task automatic test_pause();
        tick(7);
        game_state = 4'b0100;
        tick(1);
        n_cmp++; if (pipeX_1 !== 579) begin
            n_bad++; $display("FAIL pause_latency: got x1=%0d want 579", pipeX_1); end
        tick(44);
        game_state = 4'b0110;
        tick(5);
        n_cmp++; if (pipeX_1 !== 579 || pipeX_2 !== 39 || pipeX_3 !== 219 || pipeX_4 !== 399) begin
            n_bad++; $display("FAIL pause_hold: got %0d %0d %0d %0d want 579 39 219 399", pipeX_1, pipeX_2, pipeX_3, pipeX_4); end
        n_cmp++; if (score !== 10'd2 || scrolling !== 1'b0 || score_pulse !== 1'b0) begin
            n_bad++; $display("FAIL pause_flags: got score=%0d scroll=%b pulse=%b want 2 0 0", score, scrolling, score_pulse); end
        game_state = 4'b0010;
        tick(1);
        n_cmp++; if (pipeX_1 !== 579 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL resume_latency: got x1=%0d scroll=%b want 579 0", pipeX_1, scrolling); end
        tick(5);
        n_cmp++; if (pipeX_1 !== 574 || pipeX_2 !== 34 || scrolling !== 1'b1) begin
            n_bad++; $display("FAIL resume_move: got x1=%0d x2=%0d scroll=%b want 574 34 1", pipeX_1, pipeX_2, scrolling); end
    endtask

    // Pipe 3 is the next to cross (edge 100 -> 99) after 166 more moves
    task automatic test_saturation();
        force dut.r_score = 10'd999;
        #1;
        release dut.r_score;
        tick(166);
        n_cmp++; if (score !== 10'd999 || score_pulse !== 1'b0) begin
            n_bad++; $display("FAIL sat_before: got score=%0d pulse=%b want 999 0", score, score_pulse); end
        tick(1);
        n_cmp++; if (score !== 10'd999 || score_pulse !== 1'b1 || pipeX_3 !== 47) begin
            n_bad++; $display("FAIL sat_cross: got score=%0d pulse=%b x3=%0d want 999 1 47", score, score_pulse, pipeX_3); end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        tick(1);
        n_cmp++; if (pipeX_1 !== 640 || pipeX_2 !== 820 || pipeX_3 !== 1000 || pipeX_4 !== 1180 || pipeY_1 !== 182) begin
            n_bad++; $display("FAIL midrst_pos: got %0d %0d %0d %0d y1=%0d want 640 820 1000 1180 182", pipeX_1, pipeX_2, pipeX_3, pipeX_4, pipeY_1); end
        n_cmp++; if (score !== 10'd0 || score_pulse !== 1'b0 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL midrst_flags: got score=%0d pulse=%b scroll=%b want 0 0 0", score, score_pulse, scrolling); end
        rst = 1'b0;
    endtask

    task automatic test_end_relayout();
        tick(3);
        n_cmp++; if (pipeX_1 !== 638) begin
            n_bad++; $display("FAIL end_run: got x1=%0d want 638", pipeX_1); end
        game_state = 4'b1000;
        tick(3);
        n_cmp++; if (pipeX_1 !== 637 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL end_hold: got x1=%0d scroll=%b want 637 0", pipeX_1, scrolling); end
        game_state = 4'b0001;
        tick(2);
        n_cmp++; if (pipeX_1 !== 640 || pipeX_4 !== 1180 || scrolling !== 1'b0) begin
            n_bad++; $display("FAIL relayout: got x1=%0d x4=%0d scroll=%b want 640 1180 0", pipeX_1, pipeX_4, scrolling); end
    endtask

    initial begin
        rst = 1'b1; game_state = 4'b0001; birdX = 100;
        test_reset();
        test_layout();
        test_scroll();
        test_score();
        test_respawn();
        test_pause();
        test_saturation();
        test_reset_mid_run();
        test_end_relayout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pipe_scheduler
`default_nettype wire
